// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and default width.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_W = 8;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// 1-bit full subtractor: two cascaded half subtractors whose borrows are ORed.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  assign hs1_d = x ^ y;
  assign hs1_b = ~x & y;

  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a-b controller: one difference bit per clock, LSB first, through a single fs_cell.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = $clog2(W);

  state_t         state_q, state_d;
  logic [W-1:0]   a_sh_q, a_sh_d;
  logic [W-1:0]   b_sh_q, b_sh_d;
  logic [W-1:0]   res_q, res_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d;
  logic           borrow_out_q, borrow_out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cell_d;
  logic           cell_bout;
  logic           last_bit;

  fs_cell u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        // New bit enters at the MSB so bit 0 ends up holding the first result bit.
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = {cell_d, res_q[W-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          state_d      = DONE;
          diff_d       = {cell_d, res_q[W-1:1]};
          borrow_out_d = cell_bout;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      cnt_q        <= cnt_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: a W=8 instance for directed cases and a W=4 instance swept exhaustively.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;
  logic       start4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;

  int         checks = 0;
  int         errors = 0;

  logic [8:0] exp8[$];
  logic [4:0] exp4[$];
  logic [8:0] held8;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.W(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (borrow8)
  );

  serial_sub_ctrl #(.W(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
    .borrow_out (borrow4)
  );

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] t;
    t = {1'b0, x} - {1'b0, y};
    return t;
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] x, input logic [3:0] y);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y};
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input bit push);
    @(negedge clk);
    a8     = x;
    b8     = y;
    start8 = 1'b1;
    if (push) exp8.push_back(model8(x, y));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Entered at the negedge after the accept edge; scrambles a/b meanwhile and may inject ignored starts.
  task automatic waitDone(input int exp_cycles, input bit pulse_ignore);
    int cycles   = 0;
    int busy_cnt = 0;
    while (!done8 && cycles < 50) begin
      if (busy8) busy_cnt++;
      start8 = pulse_ignore && (cycles == 2 || cycles == 7);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      @(negedge clk);
      cycles++;
    end
    start8 = 1'b0;
    checkOutput("latency8", cycles, exp_cycles);
    checkOutput("busy_cycles8", busy_cnt, exp_cycles);
    @(negedge clk);
    checkOutput("done_width8", done8, 0);
  endtask

  always begin
    @(negedge clk);
    if (!rst_n) begin
      held8 = '0;
    end else if (done8) begin
      checkOutput("done8_expected", exp8.size() > 0, 1);
      if (exp8.size() > 0) begin
        held8 = exp8.pop_front();
        checkOutput("result8", {borrow8, diff8}, held8);
      end
    end else begin
      checkOutput("hold8", {borrow8, diff8}, held8);
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && done4) begin
      checkOutput("done4_expected", exp4.size() > 0, 1);
      if (exp4.size() > 0) checkOutput("result4", {borrow4, diff4}, exp4.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b1;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_busy8", busy8, 0);
    checkOutput("rst_done8", done8, 0);
    checkOutput("rst_diff8", diff8, 0);
    checkOutput("rst_borrow8", borrow8, 0);
    checkOutput("rst_busy4", busy4, 0);
    checkOutput("rst_done4", done4, 0);
    checkOutput("rst_diff4", diff4, 0);
    checkOutput("rst_borrow4", borrow4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'd200, 8'd55, 1'b1);
    waitDone(8, 1'b0);
    applyStimulus(8'd170, 8'd170, 1'b1);
    waitDone(8, 1'b0);
    applyStimulus(8'd0, 8'd255, 1'b1);
    waitDone(8, 1'b0);
    applyStimulus(8'd5, 8'd10, 1'b1);
    waitDone(8, 1'b0);

    // Extra starts at edges 3 and 8 of this operation must be ignored.
    applyStimulus(8'd100, 8'd30, 1'b1);
    waitDone(8, 1'b1);
    repeat (12) @(negedge clk);

    // Abandon an operation mid-shift; no result may ever appear for it.
    applyStimulus(8'd77, 8'd33, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy8", busy8, 0);
    checkOutput("midrst_done8", done8, 0);
    checkOutput("midrst_diff8", diff8, 0);
    checkOutput("midrst_borrow8", borrow8, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    a8     = 8'd9;
    b8     = 8'd4;
    start8 = 1'b1;
    exp8.push_back(model8(8'd9, 8'd4));
    @(negedge clk);
    start8 = 1'b0;
    waitDone(8, 1'b0);

    // Start held high: accepts every W+2 cycles, operands only matter on accept edges.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("b2b_done", done8, (i % 10) == 9);
      start8 = 1'b1;
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      if (i % 10 == 0) exp8.push_back(model8(a8, b8));
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    for (int p = 0; p < 256; p++) begin
      int n;
      @(negedge clk);
      a4     = 4'(p >> 4);
      b4     = 4'(p);
      start4 = 1'b1;
      exp4.push_back(model4(a4, b4));
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 20) begin
        @(negedge clk);
        n++;
      end
      checkOutput("latency4", n, 4);
    end
    repeat (3) @(negedge clk);

    checkOutput("sb8_empty", exp8.size(), 0);
    checkOutput("sb4_empty", exp4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001: Parameter W, default 8, SHALL set the operand/result width in bits; legal range 2..32.
REQ-002: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: start  input  1  request to begin one subtraction; sampled only in IDLE.
REQ-005: a  input  W  minuend; captured on the edge that accepts start.
REQ-006: b  input  W  subtrahend; captured on the edge that accepts start.
REQ-007: busy  output  1  high while a subtraction is in progress (state SHIFT).
REQ-008: done  output  1  single-cycle pulse marking diff/borrow_out as valid (state DONE).
REQ-009: diff  output  W  registered result a-b modulo 2^W.
REQ-010: borrow_out  output  1  registered final borrow; 1 iff a<b unsigned.

Function
REQ-011: The block SHALL compute a-b bit-serially, LSB first, one bit per clock, through a single 1-bit full-subtractor cell.
REQ-012: FSM states SHALL be IDLE, SHIFT, DONE.
REQ-013: IDLE -> SHIFT on an edge with start=1; that edge loads a and b into shift registers, clears the borrow flop and clears the bit counter.
REQ-014: Each SHIFT edge SHALL consume the LSBs of both shift registers plus the borrow flop, shift the difference bit into the result shift register MSB-ward, update the borrow flop and increment the counter.
REQ-015: SHIFT -> DONE on the edge processing bit W-1; that edge SHALL copy the result shift register to diff and the new borrow to borrow_out.
REQ-016: DONE -> IDLE unconditionally on the next edge.
REQ-017: Latency: with start accepted at edge 0, bits process at edges 1..W, done=1 for exactly the cycle between edges W and W+1.
REQ-018: busy SHALL equal (state==SHIFT); done SHALL equal (state==DONE); both combinational decodes of the state register.
REQ-019: start while in SHIFT or DONE SHALL be ignored; a, b changes outside the accepting edge SHALL have no effect.
REQ-020: Back-to-back: start held high continuously SHALL yield one accepted operation per W+2 cycles (accepted in IDLE only).
REQ-021: diff and borrow_out SHALL hold their last value from DONE until the next DONE; they SHALL NOT change during SHIFT.
REQ-022: Cell equations: d = x ^ y ^ bin; bout = (~x & y) | (~(x ^ y) & bin).
REQ-023: Counter width SHALL be $clog2(W) bits minimum; no overflow-dependent behaviour.

Reset
REQ-024: rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, diff=0, borrow_out=0, clear shift registers, counter and borrow flop.
REQ-025: Reset asserted mid-SHIFT SHALL abandon the operation; no done pulse SHALL follow release.
REQ-026: After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n=1 and start=1.

Structure
REQ-027: A shared package sub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the full-subtractor cell equations' default width constant.
REQ-028: One sub-module fs_cell (inputs x, y, bin; outputs d, bout), built from two half-subtractor stages plus an OR, SHALL be instantiated once.
REQ-029: All registers in the top in one clocked process with async reset; next-state and outputs decoded separately.

Verification
REQ-030: W=8, a=200, b=55, start one cycle -> done exactly at cycle 8 after accept edge, diff=145, borrow_out=0, busy high 8 cycles.
REQ-031: W=8, a=5, b=10 -> diff=251, borrow_out=1; a=0, b=255 -> diff=1, borrow_out=1; a=b=170 -> diff=0, borrow_out=0.
REQ-032: start pulsed again at cycles 3 and 8 of an operation -> ignored; only one done; result of first operands.
REQ-033: rst_n low at SHIFT cycle 4 -> outputs 0 immediately, no done afterwards; subsequent a=9, b=4 -> diff=5, borrow_out=0.
REQ-034: start held high for 40 cycles with W=8 -> done every 10 cycles; diff stable between pulses.
REQ-035: Self-checking bench SHALL compare every done against a behavioural a-b model over exhaustive 8-bit pairs for W=4 and report PASS count / total.
